// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, drives the instruction-memory address and
// fills the IF/ID register. Optional macro FETCH_WRAP_EN restarts at RESET_PC instead of stopping.
//
// state | meaning
// RUN   | fetching; handles branch redirect, stall and end-of-program detection
// DONE  | program finished; pc frozen, IF/ID empty, only reset leaves
module fetch_unit #(
    parameter int PC_WIDTH = 8,
    parameter int RESET_PC = 0,
    parameter int PC_STEP  = 2,
    parameter int PROG_END = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic [3:0]          im_opcode,
    input  logic [3:0]          im_a,
    input  logic [3:0]          im_b,
    input  logic [3:0]          im_w,
    output logic [PC_WIDTH-1:0] pc,
    output logic                ifid_valid,
    output logic [PC_WIDTH-1:0] ifid_pc,
    output logic [3:0]          ifid_opcode,
    output logic [3:0]          ifid_a,
    output logic [3:0]          ifid_b,
    output logic [3:0]          ifid_w,
    output logic [7:0]          ifid_fetch_count,
    output logic                done
);

    typedef enum logic {RUN, DONE} state_t;

    localparam logic [PC_WIDTH-1:0] RESET_PC_V = RESET_PC[PC_WIDTH-1:0];
    localparam logic [PC_WIDTH-1:0] STEP_V     = PC_STEP[PC_WIDTH-1:0];
    // One extra bit so PROG_END == 2^PC_WIDTH still compares correctly.
    localparam logic [PC_WIDTH:0]   END_X      = PROG_END[PC_WIDTH:0];

    state_t              state, state_nxt;
    logic [PC_WIDTH-1:0] pc_nxt;
    logic                valid_nxt;
    logic [PC_WIDTH-1:0] ifid_pc_nxt;
    logic [3:0]          opcode_nxt, a_nxt, b_nxt, w_nxt;
    logic [7:0]          count_nxt;
    logic                past_end;

    assign past_end = ({1'b0, pc} >= END_X);

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= RUN;
            pc               <= RESET_PC_V;
            ifid_valid       <= 1'b0;
            ifid_pc          <= '0;
            ifid_opcode      <= '0;
            ifid_a           <= '0;
            ifid_b           <= '0;
            ifid_w           <= '0;
            ifid_fetch_count <= '0;
        end else begin
            state            <= state_nxt;
            pc               <= pc_nxt;
            ifid_valid       <= valid_nxt;
            ifid_pc          <= ifid_pc_nxt;
            ifid_opcode      <= opcode_nxt;
            ifid_a           <= a_nxt;
            ifid_b           <= b_nxt;
            ifid_w           <= w_nxt;
            ifid_fetch_count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        valid_nxt   = ifid_valid;
        ifid_pc_nxt = ifid_pc;
        opcode_nxt  = ifid_opcode;
        a_nxt       = ifid_a;
        b_nxt       = ifid_b;
        w_nxt       = ifid_w;
        count_nxt   = ifid_fetch_count;

        case (state)
            RUN: begin
                if (branch_taken) begin
                    pc_nxt    = {branch_target[PC_WIDTH-1:1], 1'b0};
                    valid_nxt = 1'b0;
                end else if (stall) begin
                    // everything holds
                end else if (past_end) begin
                    valid_nxt = 1'b0;
`ifdef FETCH_WRAP_EN
                    pc_nxt    = RESET_PC_V;
`else
                    state_nxt = DONE;
`endif
                end else begin
                    opcode_nxt  = im_opcode;
                    a_nxt       = im_a;
                    b_nxt       = im_b;
                    w_nxt       = im_w;
                    ifid_pc_nxt = pc;
                    valid_nxt   = 1'b1;
                    pc_nxt      = pc + STEP_V;
                    if (ifid_fetch_count != 8'hFF)
                        count_nxt = ifid_fetch_count + 8'd1;
                end
            end
            DONE: begin
                valid_nxt = 1'b0;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    assign done = (state == DONE);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed test-plan scenarios plus randomized
// stall/branch/reset traffic compared every cycle against a behavioural model.
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       stall;
    logic       branch_taken;
    logic [7:0] branch_target;
    logic [3:0] im_opcode, im_a, im_b, im_w;
    logic [7:0] pc;
    logic       ifid_valid;
    logic [7:0] ifid_pc;
    logic [3:0] ifid_opcode, ifid_a, ifid_b, ifid_w;
    logic [7:0] ifid_fetch_count;
    logic       done;

    int checks = 0;
    int errors = 0;

    // Reference model state (plain integers)
    int m_pc, m_valid, m_ipc, m_fields, m_count, m_halted;

    always #5 clk = ~clk;

    fetch_unit #(.PC_WIDTH(8), .RESET_PC(0), .PC_STEP(2), .PROG_END(16)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .im_opcode(im_opcode), .im_a(im_a), .im_b(im_b), .im_w(im_w),
        .pc(pc), .ifid_valid(ifid_valid), .ifid_pc(ifid_pc),
        .ifid_opcode(ifid_opcode), .ifid_a(ifid_a), .ifid_b(ifid_b), .ifid_w(ifid_w),
        .ifid_fetch_count(ifid_fetch_count), .done(done)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_edge(input int rst, input int stl, input int br, input int tgt, input int fields);
        if (rst != 0) begin
            m_pc = 0; m_valid = 0; m_ipc = 0; m_fields = 0; m_count = 0; m_halted = 0;
        end else if (m_halted != 0) begin
            m_valid = 0;
        end else if (br != 0) begin
            m_pc    = (tgt / 2) * 2;
            m_valid = 0;
        end else if (stl != 0) begin
            // hold
        end else if (m_pc >= 16) begin
            m_valid = 0;
`ifdef FETCH_WRAP_EN
            m_pc = 0;
`else
            m_halted = 1;
`endif
        end else begin
            m_fields = fields;
            m_ipc    = m_pc;
            m_valid  = 1;
            m_pc     = (m_pc + 2) % 256;
            if (m_count < 255) m_count = m_count + 1;
        end
    endtask

    task automatic compare_all();
        check_eq("pc",     pc,                 m_pc);
        check_eq("valid",  ifid_valid,         m_valid);
        check_eq("ifid_pc", ifid_pc,           m_ipc);
        check_eq("fields", {ifid_opcode, ifid_a, ifid_b, ifid_w}, m_fields);
        check_eq("count",  ifid_fetch_count,   m_count);
        check_eq("done",   done,               m_halted);
    endtask

    // One clock: drive at negedge, advance model with the sampled inputs, compare 1 ns after the edge.
    task automatic step(input int rst, input int stl, input int br, input int tgt);
        logic [15:0] f;
        @(negedge clk);
        f             = 16'($urandom);
        reset         = (rst != 0);
        stall         = (stl != 0);
        branch_taken  = (br != 0);
        branch_target = 8'(tgt);
        {im_opcode, im_a, im_b, im_w} = f;
        @(posedge clk);
        model_edge(rst, stl, br, tgt, int'(f));
        #1;
        compare_all();
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        im_opcode = '0; im_a = '0; im_b = '0; im_w = '0;

        // Straight-line run
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 0);
`ifndef FETCH_WRAP_EN
        check_eq("tp_end_pc", pc, 16);
        check_eq("tp_end_done", done, 1);
        check_eq("tp_end_count", ifid_fetch_count, 8);
`else
        check_eq("tp_wrap_pc", pc, 0);
        check_eq("tp_wrap_done", done, 0);
        step(0, 0, 0, 0);
        check_eq("tp_wrap_ifid_pc", ifid_pc, 0);
        check_eq("tp_wrap_valid", ifid_valid, 1);
`endif
        // DONE ignores stall/branch
        step(0, 1, 1, 2);
        step(0, 0, 1, 4);

        // Stall at pc=4 for three cycles, then resume
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        check_eq("tp_stall_ifid_pc", ifid_pc, 2);
        step(0, 0, 0, 0);
        check_eq("tp_stall_resume_pc", pc, 6);

        // Branch to odd target while pc=6
        step(0, 0, 1, 8'h0B);
        check_eq("tp_branch_pc", pc, 10);
        step(0, 0, 0, 0);
        check_eq("tp_branch_ifid_pc", ifid_pc, 10);

        // Stall and branch together: branch wins
        step(0, 1, 1, 2);
        check_eq("tp_branch_stall_pc", pc, 2);

        // Reset mid-operation
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        check_eq("tp_reset_pc", pc, 0);

        // Target past PROG_END is accepted, next plain edge ends the program
        step(0, 0, 1, 8'hF3);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // Saturation: loop back to 0 whenever pc reaches 14
        step(1, 0, 0, 0);
        for (int i = 0; i < 700; i++) step(0, 0, (m_pc == 14) ? 1 : 0, 0);
        check_eq("sat_count", ifid_fetch_count, 255);

        // Randomized traffic
        step(1, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            int r, s, b, t;
            r = ($urandom_range(0, 99) < 2) ? 1 : 0;
            s = ($urandom_range(0, 99) < 25) ? 1 : 0;
            b = ($urandom_range(0, 99) < 10) ? 1 : 0;
            t = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 20));
            step(r, s, b, t);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
